// File: rtl/jmbl_countdown_if.sv
// Control/status bundle for jmbl_countdown.
//   start, selector, pause : requests from the controlling agent (master drives)
//   c, busy, done, reloads : counter status returned by the countdown block (slave drives)
interface jmbl_countdown_if #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned RLD_W = 4
);
  logic             start;
  logic             selector;
  logic             pause;
  logic [WIDTH-1:0] c;
  logic             busy;
  logic             done;
  logic [RLD_W-1:0] reloads;

  modport master (
    output start, selector, pause,
    input  c, busy, done, reloads
  );

  modport slave (
    input  start, selector, pause,
    output c, busy, done, reloads
  );
endinterface

// File: rtl/jmbl_countdown.sv
// Down-counter: on start (IDLE only) loads START and decrements to zero. In the zero cycle,
// selector chooses between auto-reload (stay RUN, bump saturating reload count) and stopping
// (return to IDLE). pause freezes everything while in RUN.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (highest priority)
//   bus  : slave side of jmbl_countdown_if (start/selector/pause in; c/busy/done/reloads out)
module jmbl_countdown #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned START = 200,
  parameter int unsigned RLD_W = 4
) (
  input logic            clk,
  input logic            rst,
  jmbl_countdown_if.slave bus
);

  localparam logic [WIDTH-1:0] StartVal = WIDTH'(START);
  localparam logic [RLD_W-1:0] RldMax   = '1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_c, w_c_next;
  logic             r_done, w_done_next;
  logic [RLD_W-1:0] r_reloads, w_reloads_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_c       <= '0;
      r_done    <= 1'b0;
      r_reloads <= '0;
    end else begin
      r_state   <= w_state_next;
      r_c       <= w_c_next;
      r_done    <= w_done_next;
      r_reloads <= w_reloads_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_c_next       = r_c;
    w_done_next    = 1'b0;
    w_reloads_next = r_reloads;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_c_next     = StartVal;
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (bus.pause) begin
          // hold everything; a pause in the c==1 or c==0 cycle defers that cycle's action
        end else if (r_c > WIDTH'(1)) begin
          w_c_next = r_c - WIDTH'(1);
        end else if (r_c == WIDTH'(1)) begin
          w_c_next    = '0;
          w_done_next = 1'b1;
        end else if (bus.selector) begin
          w_c_next = StartVal;
          if (r_reloads != RldMax) w_reloads_next = r_reloads + RLD_W'(1);
        end else begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign bus.c       = r_c;
  assign bus.busy    = (r_state == StRun);
  assign bus.done    = r_done;
  assign bus.reloads = r_reloads;

  // Safety properties
  a_c_le_start: assert property (@(posedge clk) disable iff (rst) r_c <= StartVal);
  a_done_zero:  assert property (@(posedge clk) disable iff (rst) r_done |-> (r_c == '0));
  // done is only raised from RUN and the c==1 step never leaves RUN
  a_idle_no_done: assert property (@(posedge clk) disable iff (rst)
                                   (r_state == StIdle) |-> !r_done);
  a_rld_mono: assert property (@(posedge clk) disable iff (rst)
                               !$past(rst) |-> (r_reloads >= $past(r_reloads)));

endmodule

// File: tb/tb_jmbl_countdown.sv
module tb_jmbl_countdown;
  localparam int BigStart   = 200;
  localparam int SmallStart = 3;
  localparam int RldSat     = 15;

  logic clk = 1'b0;
  logic rst;
  logic st, sel, pa;
  always #5 clk = ~clk;

  jmbl_countdown_if #(.WIDTH(11), .RLD_W(4)) big_if ();
  jmbl_countdown_if #(.WIDTH(11), .RLD_W(4)) small_if ();

  assign big_if.start      = st;
  assign big_if.selector   = sel;
  assign big_if.pause      = pa;
  assign small_if.start    = st;
  assign small_if.selector = sel;
  assign small_if.pause    = pa;

  jmbl_countdown #(.WIDTH(11), .START(BigStart), .RLD_W(4)) u_big (
    .clk (clk),
    .rst (rst),
    .bus (big_if)
  );

  jmbl_countdown #(.WIDTH(11), .START(SmallStart), .RLD_W(4)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (small_if)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer state following the behavioural rules.
  int bm_c, bm_rel, sm_c, sm_rel;
  bit bm_run, bm_done, sm_run, sm_done;

  task automatic model_step(input int start_v, input bit s, input bit se, input bit p,
                            input bit r, inout int mc, inout bit mrun, inout bit mdone,
                            inout int mrel);
    if (r) begin
      mc = 0; mrun = 0; mdone = 0; mrel = 0;
    end else begin
      mdone = 0;
      if (!mrun) begin
        if (s) begin
          mc = start_v; mrun = 1;
        end
      end else if (!p) begin
        if (mc >= 2) mc = mc - 1;
        else if (mc == 1) begin
          mc = 0; mdone = 1;
        end else if (se) begin
          mc = start_v;
          mrel = (mrel + 1 > RldSat) ? RldSat : mrel + 1;
        end else mrun = 0;
      end
    end
  endtask

  task automatic cycle(input bit s, input bit se, input bit p, input bit r);
    st = s; sel = se; pa = p; rst = r;
    @(posedge clk);
    model_step(BigStart, s, se, p, r, bm_c, bm_run, bm_done, bm_rel);
    model_step(SmallStart, s, se, p, r, sm_c, sm_run, sm_done, sm_rel);
    #1;
    check_eq("big.c", int'(big_if.c), bm_c);
    check_eq("big.busy", int'(big_if.busy), int'(bm_run));
    check_eq("big.done", int'(big_if.done), int'(bm_done));
    check_eq("big.reloads", int'(big_if.reloads), bm_rel);
    check_eq("small.c", int'(small_if.c), sm_c);
    check_eq("small.busy", int'(small_if.busy), int'(sm_run));
    check_eq("small.done", int'(small_if.done), int'(sm_done));
    check_eq("small.reloads", int'(small_if.reloads), sm_rel);
  endtask

  // Run with idle inputs until the big counter leaves RUN (bounded).
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (big_if.busy && n < 400) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check_eq(tag, int'(big_if.busy), 0);
  endtask

  initial begin
    int n;
    st = 0; sel = 0; pa = 0; rst = 1;
    bm_c = 0; bm_rel = 0; bm_run = 0; bm_done = 0;
    sm_c = 0; sm_rel = 0; sm_run = 0; sm_done = 0;

    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("reset.c", int'(big_if.c), 0);

    // 1: single countdown, stop at zero
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t1.load", int'(big_if.c), BigStart);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end while (!big_if.done && n < 400);
    check_eq("t1.len", n, BigStart);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t1.busy_drop", int'(big_if.busy), 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t1.idle_c", int'(big_if.c), 0);

    // 2: auto-reload, 3 periods; small counter saturates its reload count meanwhile
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3 * (BigStart + 1)) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t2.reloads", int'(big_if.reloads), 3);
    check_eq("t2.c", int'(big_if.c), BigStart);
    check_eq("t6.sat", int'(small_if.reloads), RldSat);
    drain("t2.stop");

    // 3: pause mid-count, then pause in the zero cycle
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (int'(big_if.c) != 120 && n < 400) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    repeat (5) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    check_eq("t3.hold", int'(big_if.c), 120);
    do begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end while (!big_if.done && n < 600);
    check_eq("t3.len", n, BigStart + 5);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t3.zero_hold", int'(big_if.busy), 1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t3.to_idle", int'(big_if.busy), 0);

    // 4: start held through a whole countdown
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end while (big_if.busy && n < 400);
    check_eq("t4.len", n, BigStart + 2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t4.reload", int'(big_if.c), BigStart);
    drain("t4.stop");

    // 5: reset mid-countdown
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (int'(big_if.c) != 57 && n < 400) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("t5.rst_c", int'(big_if.c), 0);
    check_eq("t5.rst_busy", int'(big_if.busy), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t5.restart", int'(big_if.c), BigStart);
    drain("t5.stop");

    // Random traffic
    repeat (3000) begin
      cycle(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jmbl_countdown.md
Name: jmbl_countdown

Overview:
- Down-counting companion to the saturating up-counter cases in the arithmetic property-mining suite.
- On a start request it loads a start value and decrements to zero, then either stops or auto-reloads depending on `selector`.
- Exposes busy/done status and a saturating reload count.
- Carries a built-in safety property: `c` never exceeds START.

Parameters:
- WIDTH, 11, width of counter output c.
- START, 200, value loaded on start/reload; must satisfy 1 <= START < 2^WIDTH.
- RLD_W, 4, width of reload counter (saturates at 2^RLD_W-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a countdown; honoured only in IDLE.
- selector  input  1  1 = auto-reload at zero, 0 = stop at zero; sampled in the zero cycle.
- pause  input  1  freezes the counter while high (RUN only).
- c  output  WIDTH  current count (registered).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, registered, coincident with c becoming 0.
- reloads  output  RLD_W  number of auto-reloads since reset, saturating.

Behaviour:
- Reset (rst=1 at a clk edge): c=0, busy=0, done=0, reloads=0, state=IDLE. rst has priority over every other input, including mid-countdown.
- States: IDLE, RUN. busy is 1 exactly when state=RUN.
- IDLE:
  - c holds its value.
  - start=1 -> next cycle: c=START, state=RUN.
  - pause is ignored in IDLE.
- RUN, evaluated in priority order:
  1. pause=1: c, reloads and state hold; done=0.
  2. c>1: c<=c-1; done=0.
  3. c==1: c<=0; done<=1. State remains RUN.
  4. c==0 and selector=1: c<=START; reloads<=reloads+1, saturating at 2^RLD_W-1 (no wrap); stay RUN; done=0.
  5. c==0 and selector=0: state<=IDLE; c stays 0; done=0.
- start is ignored while in RUN. It does not restart or re-arm the count.
- Timing: start high at edge t gives c=START after t, c=0 after t+START (no pauses), done high in that same cycle. Each paused cycle extends this by one.
- A pause in the c==0 cycle delays the reload/stop decision. A pause in the c==1 cycle delays done.
- done is never high for two consecutive cycles.
- Arithmetic:
  - The decrement never underflows; c==0 is never decremented.
  - The reload value is exactly START.
  - All arithmetic is unsigned, WIDTH bits.
- Required invariants (to be stated as assertions in the module):
  - c <= START at all times.
  - done implies c==0.
  - busy==0 implies done==0 or the state is IDLE-bound on the next edge.
  - reloads is non-decreasing except on reset.

Test Plan:
1. Reset, then start=1 for 1 cycle, selector=0, pause=0.
   - c=200 on the next cycle, then 199, 198, and so on.
   - c=0 with done=1 exactly 200 cycles after the load.
   - busy drops one cycle later; c stays 0 in IDLE.
2. selector=1, start once, run 3 full periods.
   - c sequence 200..1,0,200..., one done pulse per period.
   - reloads = 1, 2, 3 after each zero cycle; busy stays 1 throughout.
3. Pause handling:
   - pause=1 for 5 cycles while c=120: c holds 120 for those cycles, then 119; total countdown is 205 cycles.
   - pause held in the c==0 cycle: no reload and no IDLE transition until pause drops.
4. start held high continuously throughout a countdown: no effect in RUN. After stop to IDLE, the next start reloads 200.
5. rst=1 asserted when c=57 in RUN: next cycle c=0, busy=0, done=0, reloads=0, IDLE. A later start begins from 200.
6. Reload saturation: selector=1, run 17 periods (short run with START=3 override). reloads reaches 15 and stays 15; c never exceeds START on any cycle (assertion check).
